// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter: op and state encodings plus
// the per-bit op-to-J/K mapping used by both the driver and the verify model.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        JK_OP_HOLD = 2'b00,
        JK_OP_CLR  = 2'b01,
        JK_OP_SET  = 2'b10,
        JK_OP_TGL  = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } jk_state_e;

    // Returns {J,K} for one bank bit; an unmasked bit is left alone (J=K=0).
    function automatic logic [1:0] jk_op_to_jk(input logic [1:0] op, input logic mask);
        logic [1:0] jk;
        jk = 2'b00;
        if (mask) begin
            case (op)
                JK_OP_HOLD: jk = 2'b00;
                JK_OP_CLR:  jk = 2'b01;
                JK_OP_SET:  jk = 2'b10;
                JK_OP_TGL:  jk = 2'b11;
                default:    jk = 2'b00;
            endcase
        end
        return jk;
    endfunction

    // Characteristic equation of a JK flip-flop: Q+ = J&~Q | ~K&Q.
    function automatic logic jk_next_q(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ, returned both one-hot and as an index.
module jk_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IW = $clog2(NUM_REQ);

    int          cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        onehot   = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IW-1:0];
            if (!found && req[cand_idx]) begin
                found            = 1'b1;
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop bank among NUM_REQ requesters.
// Optional post-op readback check enabled by defining JK_ARB_VERIFY_EN.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BANK_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [NUM_REQ*BANK_W-1:0] req_mask,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [BANK_W-1:0]         rd_data,
    output logic [BANK_W-1:0]         bank_j,
    output logic [BANK_W-1:0]         bank_k,
    input  logic [BANK_W-1:0]         bank_q,
    output logic                      busy,
    output logic                      vfy_err
);

    localparam int IW = $clog2(NUM_REQ);

    jk_state_e           state_reg, state_next;
    logic [IW-1:0]       ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  done_reg, done_next;
    logic [1:0]          op_reg, op_next;
    logic [BANK_W-1:0]   mask_reg, mask_next;
    logic [BANK_W-1:0]   rd_reg, rd_next;

    logic [1:0]          op_arr   [NUM_REQ];
    logic [BANK_W-1:0]   mask_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]   = req_op[2*gi +: 2];
            assign mask_arr[gi] = req_mask[BANK_W*gi +: BANK_W];
        end
    endgenerate

    jk_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // ACK re-arbitrates like IDLE so back-to-back ops run every 3 cycles.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        op_next    = op_reg;
        mask_next  = mask_reg;
        rd_next    = rd_reg;
        case (state_reg)
            ST_IDLE, ST_ACK: begin
                if (pick_found) begin
                    state_next = ST_DRIVE;
                    gnt_next   = pick_onehot;
                    op_next    = op_arr[pick_idx];
                    mask_next  = mask_arr[pick_idx];
                    ptr_next   = (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                end
            end
            ST_DRIVE: begin
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_next = ST_ACK;
                done_next  = gnt_reg;
                rd_next    = bank_q;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            op_reg    <= '0;
            mask_reg  <= '0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            op_reg    <= op_next;
            mask_reg  <= mask_next;
            rd_reg    <= rd_next;
        end
    end

    // J/K are only ever nonzero during the single DRIVE cycle.
    logic [1:0] jk_bit [BANK_W];
    generate
        for (gi = 0; gi < BANK_W; gi++) begin : g_jk
            assign jk_bit[gi] = (state_reg == ST_DRIVE) ? jk_op_to_jk(op_reg, mask_reg[gi]) : 2'b00;
            assign bank_j[gi] = jk_bit[gi][1];
            assign bank_k[gi] = jk_bit[gi][0];
        end
    endgenerate

    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign rd_data = rd_reg;
    assign busy    = (state_reg != ST_IDLE);

`ifdef JK_ARB_VERIFY_EN
    logic [BANK_W-1:0] snap_reg;
    logic [BANK_W-1:0] expect_q;
    logic              vfy_err_reg;

    generate
        for (gi = 0; gi < BANK_W; gi++) begin : g_vfy
            logic [1:0] jk_v;
            assign jk_v         = jk_op_to_jk(op_reg, mask_reg[gi]);
            assign expect_q[gi] = jk_next_q(jk_v[1], jk_v[0], snap_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_reg    <= '0;
            vfy_err_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE || state_reg == ST_ACK) && pick_found) begin
                snap_reg <= bank_q;
            end
            if (state_reg == ST_SETTLE && bank_q != expect_q) begin
                vfy_err_reg <= 1'b1;
            end
        end
    end

    assign vfy_err = vfy_err_reg;
`else
    assign vfy_err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural JK bank model;
// the stuck-bit scenario checks vfy_err when JK_ARB_VERIFY_EN is defined.
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [31:0] req_mask;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rd_data;
    logic [7:0]  bank_j;
    logic [7:0]  bank_k;
    logic [7:0]  bank_q;
    logic        busy;
    logic        vfy_err;

    logic        bank_clr = 1'b1;
    logic        stuck0   = 1'b0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    jk_bank_arbiter #(
        .NUM_REQ (4),
        .BANK_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_op   (req_op),
        .req_mask (req_mask),
        .gnt      (gnt),
        .done     (done),
        .rd_data  (rd_data),
        .bank_j   (bank_j),
        .bank_k   (bank_k),
        .bank_q   (bank_q),
        .busy     (busy),
        .vfy_err  (vfy_err)
    );

    always #5 clk = ~clk;

    // Bank of JK flip-flops; stuck0 pins bit 0 low to provoke a verify error.
    always @(posedge clk) begin
        if (bank_clr) bank_q <= 8'h00;
        else          bank_q <= ((bank_j & ~bank_q) | (~bank_k & bank_q)) & ~{7'b0, stuck0};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] rq, input logic [7:0] ops,
                          input logic [31:0] masks, input logic [3:0] exp_gnt,
                          input logic [7:0] exp_j, input logic [7:0] exp_k, input logic [7:0] exp_rd);
        req = rq; req_op = ops; req_mask = masks;
        tick();
        chk({tag, " gnt"},    32'(gnt),    32'(exp_gnt));
        chk({tag, " j"},      32'(bank_j), 32'(exp_j));
        chk({tag, " k"},      32'(bank_k), 32'(exp_k));
        // scrambling inputs after grant must not affect the latched op
        req_op = ~ops; req_mask = ~masks;
        tick();
        chk({tag, " settle_jk"}, 32'({bank_j, bank_k}), 32'h0);
        tick();
        chk({tag, " done"},   32'(done),    32'(exp_gnt));
        chk({tag, " rd"},     32'(rd_data), 32'(exp_rd));
        req = 4'b0000;
        tick();
        chk({tag, " idle_busy"}, 32'(busy), 32'h0);
        chk({tag, " idle_gnt"},  32'(gnt),  32'h0);
        chk({tag, " idle_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        reset = 1'b1; req = 4'b0000; req_op = 8'h00; req_mask = 32'h0;
        tick(); tick();
        bank_clr = 1'b0;
        reset = 1'b0;
        chk("rst gnt",  32'(gnt),     32'h0);
        chk("rst done", 32'(done),    32'h0);
        chk("rst rd",   32'(rd_data), 32'h0);
        chk("rst busy", 32'(busy),    32'h0);
        chk("rst jk",   32'({bank_j, bank_k}), 32'h0);
        chk("rst vfy",  32'(vfy_err), 32'h0);

        run_op("set0",  4'b0001, 8'h02, 32'h0000_000F, 4'b0001, 8'h0F, 8'h00, 8'h0F);
        run_op("tgl0a", 4'b0001, 8'h03, 32'h0000_00FF, 4'b0001, 8'hFF, 8'hFF, 8'hF0);
        run_op("tgl0b", 4'b0001, 8'h03, 32'h0000_00FF, 4'b0001, 8'hFF, 8'hFF, 8'h0F);
        run_op("clr1",  4'b0010, 8'h04, 32'h0000_3C00, 4'b0010, 8'h00, 8'h3C, 8'h03);
        run_op("hold2", 4'b0100, 8'h00, 32'h00FF_0000, 4'b0100, 8'h00, 8'h00, 8'h03);
        run_op("mask0", 4'b0100, 8'h20, 32'h0000_0000, 4'b0100, 8'h00, 8'h00, 8'h03);

        // Contention: pointer back to 0, all four requesting hold continuously.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1111; req_op = 8'h00; req_mask = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            chk($sformatf("cont%0d gnt", k), 32'(gnt), 32'(exp_g));
            chk($sformatf("cont%0d jk", k), 32'({bank_j, bank_k}), 32'h0);
            tick(); tick();
            chk($sformatf("cont%0d done", k), 32'(done), 32'(exp_g));
            chk($sformatf("cont%0d rd", k), 32'(rd_data), 32'h03);
            if (k == 4) req = 4'b0000;
        end
        tick();
        chk("cont idle_busy", 32'(busy), 32'h0);

        // Pointer wrap: 3 -> 0 -> 3.
        run_op("wrap3", 4'b1000, 8'h80, 32'h8000_0000, 4'b1000, 8'h80, 8'h00, 8'h83);
        run_op("wrap0", 4'b1001, 8'h03, 32'hFF00_0001, 4'b0001, 8'h01, 8'h01, 8'h82);
        run_op("wrap3b", 4'b1001, 8'h40, 32'h8000_0000, 4'b1000, 8'h00, 8'h80, 8'h02);

        // Reset in DRIVE: bank keeps what it latched, pointer returns to 0.
        req = 4'b0100; req_op = 8'h20; req_mask = 32'h00F0_0000;
        tick();
        chk("rstdrv gnt", 32'(gnt),    32'h4);
        chk("rstdrv j",   32'(bank_j), 32'hF0);
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0;
        chk("rstdrv gnt0",  32'(gnt),  32'h0);
        chk("rstdrv done0", 32'(done), 32'h0);
        chk("rstdrv jk0",   32'({bank_j, bank_k}), 32'h0);
        chk("rstdrv busy0", 32'(busy), 32'h0);
        chk("rstdrv rd0",   32'(rd_data), 32'h0);
        run_op("after_rst", 4'b1001, 8'h00, 32'hFFFF_FFFF, 4'b0001, 8'h00, 8'h00, 8'hF2);
        chk("vfy clean", 32'(vfy_err), 32'h0);

        // Bit 0 stuck low while requester 0 sets it.
        stuck0 = 1'b1;
        run_op("stuck", 4'b0001, 8'h02, 32'h0000_0001, 4'b0001, 8'h01, 8'h00, 8'hF2);
`ifdef JK_ARB_VERIFY_EN
        chk("vfy set", 32'(vfy_err), 32'h1);
        repeat (10) tick();
        chk("vfy sticky", 32'(vfy_err), 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("vfy cleared", 32'(vfy_err), 32'h0);
`else
        chk("vfy tied0", 32'(vfy_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of BANK_W JK flip-flops between NUM_REQ requesters.
- Each requester asks for one masked operation on the bank: hold/read, clear, set or toggle.
- The block arbitrates round-robin, drives the bank's J/K lines for exactly one clock, then returns the bank's post-operation Q to the winner with a done pulse.
- It sits between control FSMs and the flip-flop bank and is the only driver of the bank's J/K inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BANK_W, 8, number of JK flip-flops in the shared bank.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk only.
- req  in  NUM_REQ  request per requester; held high until that requester's done.
- req_op  in  2*NUM_REQ  op for requester i in bits [2i+1:2i]: 00 hold/read, 01 clear, 10 set, 11 toggle.
- req_mask  in  NUM_REQ*BANK_W  bit mask for requester i in bits [BANK_W*i +: BANK_W]; 1 = bit affected.
- gnt  out  NUM_REQ  one-hot grant, high from DRIVE through ACK.
- done  out  NUM_REQ  one-cycle pulse to the granted requester in ACK.
- rd_data  out  BANK_W  bank Q captured after the operation; valid while done is high, held until the next capture.
- bank_j  out  BANK_W  J vector to the bank.
- bank_k  out  BANK_W  K vector to the bank.
- bank_q  in  BANK_W  Q vector from the bank.
- busy  out  1  high in any state other than IDLE.
- vfy_err  out  1  sticky verify error (see Optional Feature).

Behaviour:
- State machine has four states: IDLE, DRIVE, SETTLE, ACK.
- Reset:
  - state = IDLE, round-robin pointer = 0.
  - gnt, done, rd_data, busy, vfy_err = 0.
  - bank_j = bank_k = 0 from the first post-reset cycle.
- Reset mid-operation aborts the operation; the bank keeps whatever it already latched.
- IDLE or ACK, when any req is high:
  - Pick the first requester at or after the pointer, with modulo wrap.
  - Latch its op and mask; gnt becomes one-hot for the winner.
  - Pointer becomes winner+1 mod NUM_REQ; go to DRIVE.
  - With no req: IDLE stays in IDLE; ACK goes to IDLE.
- DRIVE (exactly 1 cycle), per bit b:
  - mask[b]=0 gives J=K=0.
  - Otherwise: hold gives J=0, K=0; clear gives J=0, K=1; set gives J=1, K=0; toggle gives J=1, K=1.
  - Next state is SETTLE.
- SETTLE:
  - bank_j = bank_k = 0; the bank has updated on the DRIVE→SETTLE edge.
  - On the SETTLE→ACK edge, rd_data <= bank_q and done[winner] <= 1.
- ACK: done high for this single cycle; gnt stays asserted; arbitration is performed again, as in IDLE.
- J/K are combinational from state plus the latched op/mask. They are nonzero only in DRIVE.
- Latency: req sampled at edge N gives DRIVE after N, done high between edges N+2 and N+3.
- Sustained throughput is one operation per 3 cycles.
- A req dropped before it is granted is not serviced. A req dropped after grant still completes.
- The granted requester's own req, if still high in ACK, is lowest priority because the pointer has moved past it.
- Op and mask are latched at grant; later changes on the inputs are ignored.

Optional Feature:
- JK_ARB_VERIFY_EN defined:
  - On entry to DRIVE, snapshot bank_q.
  - Compute expected per bit: unmasked bit = snapshot; clear → 0; set → 1; toggle → ~snapshot; hold → snapshot.
  - On the SETTLE→ACK edge compare bank_q with expected. Any mismatch sets vfy_err, which stays set until reset.
- JK_ARB_VERIFY_EN undefined: no snapshot or compare logic; vfy_err tied to 0.

Decomposition:
- Shared package jk_bank_pkg holds:
  - op encodings JK_OP_HOLD/CLR/SET/TGL.
  - state encodings for IDLE/DRIVE/SETTLE/ACK.
  - function jk_op_to_jk(op, mask) returning the {J,K} vectors, reused by the verify model.
- One sub-module: jk_rr_pick. It is combinational round-robin selection from req and pointer to a one-hot winner plus index, parameterized by NUM_REQ.

Test Plan:
- Reset, then req=0001, op0=10 (set), mask0=0x0F, bank starting at 0x00:
  - gnt=0001 at the 1st edge.
  - bank_j=0x0F, bank_k=0x00 for one cycle.
  - done[0] at edge 3, rd_data=0x0F, busy low afterwards.
- Toggle, starting from bank 0x0F: op0=11, mask0=0xFF → rd_data=0xF0. A second toggle gives 0x0F.
- Contention: req=1111 held continuously, all ops hold → grants in order 0,1,2,3,0, one done every 3 cycles, no gaps.
- Pointer wrap: grant requester 3, then req=1001 → next grant is 0; then req=1001 again → grant 3.
- Reset asserted in DRIVE:
  - next cycle gnt=0, done=0, J=K=0, state IDLE.
  - the following request is granted to requester 0 (pointer reset).
- With JK_ARB_VERIFY_EN: bank model forces bit 0 stuck at 0, op set with mask 0x01 → vfy_err=1, still 1 after 10 idle cycles, cleared only by reset.
